// File: rtl/control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback for
// 16-bit instructions and drives all datapath enables, mux selects and ALU ops.
module control_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   input  logic [4:0]  flags,
   output logic        irEn,
   output logic        pcRegEn,
   output logic        srcRegEn,
   output logic        dstRegEn,
   output logic        immRegEn,
   output logic        resultRegEn,
   output logic        signEn,
   output logic        regFileEn,
   output logic        exMemResultEn,
   output logic        pcRegMuxEn,
   output logic [1:0]  mux4En,
   output logic        shiftALUMuxEn,
   output logic        regImmMuxEn,
   output logic [1:0]  regpcCont,
   output logic [3:0]  aluControl,
   output logic        memWrite,
   output logic        flagEn
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_R  = 4'd2,
      EXEC_I  = 4'd3,
      SHIFT_R = 4'd4,
      SHIFT_I = 4'd5,
      WB      = 4'd6,
      LD_ADR  = 4'd7,
      LD_WB   = 4'd8,
      STORE   = 4'd9,
      BRANCH  = 4'd10
   } state_t;

   typedef struct packed {
      logic       ir;
      logic       pc;
      logic       src;
      logic       dst;
      logic       imm;
      logic       res;
      logic       sgn;
      logic       rf;
      logic       exm;
      logic       pcmux;
      logic [1:0] m4;
      logic       sh;
      logic       ri;
      logic [1:0] rpc;
      logic [3:0] alu;
      logic       mw;
      logic       fe;
   } ctl_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_CMP = 4'b0101;
   localparam logic [3:0] ALU_MOV = 4'b0110;

   // Returns {legal, aluControl} for an ALU op code (ext field or immediate OpCode).
   function automatic logic [4:0] alu_map(input logic [3:0] code);
      logic [4:0] r;
      case (code)
         4'b0101: r = {1'b1, 4'b0000};
         4'b1001: r = {1'b1, 4'b0001};
         4'b0001: r = {1'b1, 4'b0010};
         4'b0010: r = {1'b1, 4'b0011};
         4'b0011: r = {1'b1, 4'b0100};
         4'b1011: r = {1'b1, 4'b0101};
         4'b1101: r = {1'b1, 4'b0110};
         default: r = {1'b0, 4'b0000};
      endcase
      return r;
   endfunction

   function automatic logic flag_op(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_CMP);
   endfunction

   function automatic logic sign_op(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_CMP) || (op == ALU_MOV);
   endfunction

   state_t     state_r;
   state_t     nxt_s;
   logic       run_r;
   ctl_t       ctl_r;
   ctl_t       ctl_s;
   logic [3:0] opc_s;
   logic [3:0] ext_s;
   logic [3:0] cond_s;
   logic [4:0] alu_r_s;
   logic [4:0] alu_i_s;
   logic       taken_s;
   logic       unused_bits_s;

   assign opc_s   = instruction[15:12];
   assign cond_s  = instruction[11:8];
   assign ext_s   = instruction[7:4];
   assign alu_r_s = alu_map(ext_s);
   assign alu_i_s = alu_map(opc_s);
   assign taken_s = ((cond_s == 4'b0000) && flags[1]) ||
                    ((cond_s == 4'b0001) && !flags[1]) ||
                    (cond_s == 4'b1110);
   // Source register and the C/L/F/N flags play no part in sequencing.
   assign unused_bits_s = ^{instruction[3:0], flags[4:2], flags[0]};

   // Next-state selection; the first cycle after reset is held in the reset state.
   always_comb begin
      nxt_s = FETCH;
      if (!run_r) begin
         nxt_s = state_t'(RESET_STATE);
      end else begin
         case (state_r)
            FETCH:   nxt_s = DECODE;
            DECODE: begin
               case (opc_s)
                  4'b0000: nxt_s = alu_r_s[4] ? EXEC_R : FETCH;
                  4'b1000: begin
                     if (ext_s == 4'b0100)            nxt_s = SHIFT_R;
                     else if (ext_s[3:1] == 3'b000)   nxt_s = SHIFT_I;
                     else                             nxt_s = FETCH;
                  end
                  4'b0100: begin
                     if (ext_s == 4'b0000)            nxt_s = LD_ADR;
                     else if (ext_s == 4'b0100)       nxt_s = STORE;
                     else                             nxt_s = FETCH;
                  end
                  4'b1100: nxt_s = BRANCH;
                  default: nxt_s = alu_i_s[4] ? EXEC_I : FETCH;
               endcase
            end
            EXEC_R:  nxt_s = (alu_r_s[3:0] == ALU_CMP) ? FETCH : WB;
            EXEC_I:  nxt_s = (alu_i_s[3:0] == ALU_CMP) ? FETCH : WB;
            SHIFT_R: nxt_s = WB;
            SHIFT_I: nxt_s = WB;
            WB:      nxt_s = FETCH;
            LD_ADR:  nxt_s = LD_WB;
            LD_WB:   nxt_s = FETCH;
            STORE:   nxt_s = FETCH;
            BRANCH:  nxt_s = FETCH;
            default: nxt_s = FETCH;
         endcase
      end
   end

   // Control word for the state being entered, so outputs come straight from flops.
   always_comb begin
      ctl_s = '0;
      case (nxt_s)
         FETCH: begin
            ctl_s.ir  = 1'b1;
            ctl_s.rpc = 2'b01;
         end
         DECODE: begin
            ctl_s.src = 1'b1;
            ctl_s.dst = 1'b1;
            ctl_s.imm = 1'b1;
            ctl_s.m4  = 2'b10;
            ctl_s.pc  = 1'b1;
         end
         EXEC_R: begin
            ctl_s.pcmux = 1'b1;
            ctl_s.res   = 1'b1;
            ctl_s.alu   = alu_r_s[3:0];
            ctl_s.fe    = flag_op(alu_r_s[3:0]);
         end
         EXEC_I: begin
            ctl_s.m4    = 2'b01;
            ctl_s.pcmux = 1'b1;
            ctl_s.res   = 1'b1;
            ctl_s.alu   = alu_i_s[3:0];
            ctl_s.fe    = flag_op(alu_i_s[3:0]);
            ctl_s.sgn   = sign_op(alu_i_s[3:0]);
         end
         SHIFT_R, SHIFT_I: begin
            ctl_s.sh  = 1'b1;
            ctl_s.res = 1'b1;
            ctl_s.ri  = (nxt_s == SHIFT_I);
            ctl_s.sgn = 1'b1;
         end
         WB:      ctl_s.rf = 1'b1;
         LD_ADR:  ctl_s.rpc = 2'b00;
         LD_WB: begin
            ctl_s.exm = 1'b1;
            ctl_s.rf  = 1'b1;
         end
         STORE:   ctl_s.mw = 1'b1;
         BRANCH: begin
            if (taken_s) begin
               ctl_s.m4  = 2'b01;
               ctl_s.sgn = 1'b1;
               ctl_s.pc  = 1'b1;
            end else begin
               ctl_s.pc  = 1'b0;
            end
         end
         default: ctl_s = '0;
      endcase
   end

   // State and output registers; reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= state_t'(RESET_STATE);
         run_r   <= 1'b0;
         ctl_r   <= '0;
      end else begin
         state_r <= nxt_s;
         run_r   <= 1'b1;
         ctl_r   <= ctl_s;
      end
   end

   assign irEn          = ctl_r.ir;
   assign pcRegEn       = ctl_r.pc;
   assign srcRegEn      = ctl_r.src;
   assign dstRegEn      = ctl_r.dst;
   assign immRegEn      = ctl_r.imm;
   assign resultRegEn   = ctl_r.res;
   assign signEn        = ctl_r.sgn;
   assign regFileEn     = ctl_r.rf;
   assign exMemResultEn = ctl_r.exm;
   assign pcRegMuxEn    = ctl_r.pcmux;
   assign mux4En        = ctl_r.m4;
   assign shiftALUMuxEn = ctl_r.sh;
   assign regImmMuxEn   = ctl_r.ri;
   assign regpcCont     = ctl_r.rpc;
   assign aluControl    = ctl_r.alu;
   assign memWrite      = ctl_r.mw;
   assign flagEn        = ctl_r.fe;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected control sequences built from
// the instruction-set rules, compared cycle by cycle on the falling edge.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instruction = 16'h0000;
   logic [4:0]  flags = 5'b00000;
   logic        irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn;
   logic        regFileEn, exMemResultEn, pcRegMuxEn, shiftALUMuxEn, regImmMuxEn;
   logic        memWrite, flagEn;
   logic [1:0]  mux4En, regpcCont;
   logic [3:0]  aluControl;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk(clk), .reset(reset), .instruction(instruction), .flags(flags),
      .irEn(irEn), .pcRegEn(pcRegEn), .srcRegEn(srcRegEn), .dstRegEn(dstRegEn),
      .immRegEn(immRegEn), .resultRegEn(resultRegEn), .signEn(signEn),
      .regFileEn(regFileEn), .exMemResultEn(exMemResultEn), .pcRegMuxEn(pcRegMuxEn),
      .mux4En(mux4En), .shiftALUMuxEn(shiftALUMuxEn), .regImmMuxEn(regImmMuxEn),
      .regpcCont(regpcCont), .aluControl(aluControl), .memWrite(memWrite), .flagEn(flagEn)
   );

   typedef struct packed {
      logic       ir, pc, src, dst, imm, res, sgn, rf, exm, pcmux;
      logic [1:0] m4;
      logic       sh, ri;
      logic [1:0] rpc;
      logic [3:0] alu;
      logic       mw, fe;
   } outs_t;

   outs_t obs;
   assign obs = {irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn,
                 regFileEn, exMemResultEn, pcRegMuxEn, mux4En, shiftALUMuxEn,
                 regImmMuxEn, regpcCont, aluControl, memWrite, flagEn};

   outs_t exp_q[$];
   int total = 0;
   int bad = 0;

   // Instruction-set table: op code -> ALU control value.
   logic [3:0] op_code_tab [7] = '{4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1011};
   logic [3:0] op_alu_tab  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd5};

   function automatic int lookup(input logic [3:0] c);
      for (int k = 0; k < 7; k++) if (op_code_tab[k] == c) return k;
      return -1;
   endfunction

   function automatic void push_alu(input logic [3:0] op, input logic is_imm);
      outs_t e;
      e = '0;
      e.pcmux = 1'b1;
      e.res   = 1'b1;
      e.alu   = op;
      e.fe    = (op == 4'd0) || (op == 4'd1) || (op == 4'd5);
      if (is_imm) begin
         e.m4  = 2'b01;
         e.sgn = (op == 4'd0) || (op == 4'd1) || (op == 4'd5) || (op == 4'd6);
      end
      exp_q.push_back(e);
      if (op != 4'd5) begin
         e = '0;
         e.rf = 1'b1;
         exp_q.push_back(e);
      end
   endfunction

   function automatic void build_exp(input logic [15:0] ins, input logic [4:0] fl);
      outs_t e;
      logic [3:0] opc, cnd, ext;
      logic taken;
      opc = ins[15:12];
      cnd = ins[11:8];
      ext = ins[7:4];
      exp_q.delete();
      e = '0; e.ir = 1'b1; e.rpc = 2'b01;
      exp_q.push_back(e);
      e = '0; e.src = 1'b1; e.dst = 1'b1; e.imm = 1'b1; e.m4 = 2'b10; e.pc = 1'b1;
      exp_q.push_back(e);
      if (opc == 4'd0 && lookup(ext) >= 0) begin
         push_alu(op_alu_tab[lookup(ext)], 1'b0);
      end else if (lookup(opc) >= 0) begin
         push_alu(op_alu_tab[lookup(opc)], 1'b1);
      end else if (opc == 4'd8 && (ext == 4'd4 || ext == 4'd0 || ext == 4'd1)) begin
         e = '0; e.sh = 1'b1; e.res = 1'b1; e.sgn = 1'b1; e.ri = (ext != 4'd4);
         exp_q.push_back(e);
         e = '0; e.rf = 1'b1;
         exp_q.push_back(e);
      end else if (opc == 4'd4 && ext == 4'd0) begin
         e = '0;
         exp_q.push_back(e);
         e.exm = 1'b1; e.rf = 1'b1;
         exp_q.push_back(e);
      end else if (opc == 4'd4 && ext == 4'd4) begin
         e = '0; e.mw = 1'b1;
         exp_q.push_back(e);
      end else if (opc == 4'd12) begin
         taken = (cnd == 4'd0 && fl[1]) || (cnd == 4'd1 && !fl[1]) || (cnd == 4'd14);
         e = '0;
         if (taken) begin
            e.m4 = 2'b01; e.sgn = 1'b1; e.pc = 1'b1;
         end
         exp_q.push_back(e);
      end
   endfunction

   // Runs one instruction; cut > 0 stops checking after that many cycles.
   task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input int cut,
                            input string name);
      int n;
      build_exp(ins, fl);
      n = exp_q.size();
      if (cut > 0 && cut < n) n = cut;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (obs !== exp_q[i]) begin
            bad++;
            $display("FAIL %s cyc%0d instr=%h flags=%b got=%h want=%h",
                     name, i, ins, fl, obs, exp_q[i]);
         end
         if (i == 0) begin
            instruction = ins;
            flags = fl;
         end
      end
   endtask

   task automatic do_reset(input int n, input string name);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (obs !== outs_t'(0)) begin
            bad++;
            $display("FAIL %s cyc%0d got=%h want=0", name, i, obs);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(3, "reset_hold");
   endtask

   task automatic test_alu();
      run_instr(16'h0355, 5'b00000, 0, "add_r");
      run_instr(16'hB2FF, 5'b00010, 0, "cmpi");
      run_instr(16'h0BB1, 5'b00000, 0, "cmp_r");
      run_instr(16'h1234, 5'b00000, 0, "andi");
      run_instr(16'hD7F0, 5'b00000, 0, "movi");
      run_instr(16'h8042, 5'b00000, 0, "shift_r");
      run_instr(16'h8013, 5'b00000, 0, "shift_i");
   endtask

   task automatic test_mem();
      run_instr(16'h4104, 5'b00000, 0, "load");
      run_instr(16'h4144, 5'b00000, 0, "store");
   endtask

   task automatic test_branch();
      run_instr(16'hC0FD, 5'b00010, 0, "beq_taken");
      run_instr(16'hC0FD, 5'b00000, 0, "beq_not");
      run_instr(16'hC105, 5'b00000, 0, "bne_taken");
      run_instr(16'hCE80, 5'b00010, 0, "b_always");
      run_instr(16'hC3FF, 5'b11111, 0, "b_never");
   endtask

   task automatic test_illegal();
      run_instr(16'hF000, 5'b00000, 0, "illegal_f");
      run_instr(16'h0000, 5'b00000, 0, "illegal_ext");
      run_instr(16'h8020, 5'b00000, 0, "illegal_shift");
      run_instr(16'h4120, 5'b00000, 0, "illegal_mem");
   endtask

   task automatic test_reset_mid();
      run_instr(16'h4104, 5'b00000, 3, "load_cut");
      do_reset(3, "reset_in_ld_adr");
      run_instr(16'h0355, 5'b00000, 0, "after_reset");
   endtask

   function automatic logic [15:0] rand_instr();
      logic [3:0] pick, ext;
      pick = 4'($urandom_range(0, 9));
      ext = op_code_tab[$urandom_range(0, 6)];
      case (pick)
         4'd0, 4'd1, 4'd2: return {4'h0, 4'($urandom), ext, 4'($urandom)};
         4'd3, 4'd4:       return {ext, 8'($urandom), 4'($urandom)};
         4'd5:             return {4'h8, 4'($urandom), 4'($urandom_range(0, 5)), 4'($urandom)};
         4'd6:             return {4'h4, 4'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h4, 4'($urandom)};
         4'd7:             return {4'hC, ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 2)), 8'($urandom)};
         default:          return 16'($urandom);
      endcase
   endfunction

   task automatic test_back_to_back();
      logic [15:0] ins;
      for (int t = 0; t < 300; t++) begin
         ins = rand_instr();
         if ($urandom_range(0, 19) == 0) begin
            run_instr(ins, 5'($urandom), int'($urandom_range(1, 4)), "rand_cut");
            do_reset(int'($urandom_range(1, 3)), "rand_reset");
         end else begin
            run_instr(ins, 5'($urandom), 0, "rand");
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multicycle control unit that sits directly upstream of the processor datapath. It sequences fetch, decode, execute, memory and writeback for each 16-bit instruction and drives every datapath enable, mux select and ALU opcode. It also drives the instruction-register latch, the memory write strobe and the PSR flag update.

Parameters:
RESET_STATE, 4'd0, state encoding loaded on reset (FETCH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
instruction  input  16  latched IR: [15:12] OpCode, [11:8] Rdest, [7:4] OpCodeExt/imm hi, [3:0] Rsrc/imm lo
flags  input  5  registered PSR {C,L,F,Z,N}
irEn  output  1  IR loads memdata
pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn  output  1 each  datapath register enables
signEn  output  1  1 = sign-extend immediate, 0 = zero-extend
regFileEn  output  1  register file write (address = dst)
exMemResultEn  output  1  regfile write data: 0 result, 1 memdata
pcRegMuxEn  output  1  ALU b: 0 pc, 1 srcData
mux4En  output  2  ALU a: 00 dstData, 01 imm, 10 const 1, 11 const 0
shiftALUMuxEn  output  1  0 ALU, 1 shifter into result
regImmMuxEn  output  1  shift amount: 0 srcData, 1 imm
regpcCont  output  2  address: 00 srcData, 01 pc, 10 result, 11 zero
aluControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 CMP, 0110 MOV
memWrite  output  1  memory write strobe, data = dstData
flagEn  output  1  PSR captures ALU flags

Behaviour:
- Moore FSM; all outputs decode from the current state and the latched OpCode/OpCodeExt. Every output not listed for a state is 0.
- Reset: while reset = 0 at a rising edge, state <= FETCH. Reset wins over any transition, including mid-instruction; the partial instruction is abandoned with no regfile write or memWrite. While reset is low, all outputs are forced to 0.
- FETCH: regpcCont=01, irEn=1 -> DECODE.
- DECODE: srcRegEn=dstRegEn=immRegEn=1; PC increment via mux4En=10, pcRegMuxEn=0, ADD, pcRegEn=1. Next state comes from the instruction:
  - OpCode 0000, ext {0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV, 1011 CMP} -> EXEC_R
  - OpCode {0101,1001,0001,0010,0011,1101,1011} (immediate forms, same op mapping) -> EXEC_I
  - OpCode 1000: ext 0100 -> SHIFT_R; ext 000x -> SHIFT_I
  - OpCode 0100: ext 0000 -> LD_ADR; ext 0100 -> STORE
  - OpCode 1100 -> BRANCH
  - anything else -> FETCH (NOP; 2 cycles)
- EXEC_R: mux4En=00, pcRegMuxEn=1, aluControl per ext, resultRegEn=1, flagEn=1 for ADD/SUB/CMP. CMP -> FETCH; others -> WB.
- EXEC_I: as EXEC_R but mux4En=01. signEn=1 for ADD/SUB/CMP/MOV, 0 for AND/OR/XOR.
- SHIFT_R / SHIFT_I: shiftALUMuxEn=1, resultRegEn=1, regImmMuxEn=0/1, signEn=1 -> WB.
- WB: regFileEn=1, exMemResultEn=0 -> FETCH.
- LD_ADR: regpcCont=00 -> LD_WB. LD_WB: regpcCont=00 held, exMemResultEn=1, regFileEn=1 -> FETCH.
- STORE: regpcCont=00, memWrite=1 for exactly one cycle -> FETCH.
- BRANCH: the condition is Rdest.
  - 0000 EQ (Z=1), 0001 NE (Z=0), 1110 always; any other code is never taken.
  - Taken: mux4En=01, signEn=1, pcRegMuxEn=0, ADD, pcRegEn=1, so target = (pc+1) + sext(disp). Not taken: no enables.
  - -> FETCH.
- Latencies in cycles: R/I ALU op 4, CMP/CMPI 3, shift 4, load 4, store 3, branch 3, NOP 2.
- PC arithmetic is 16-bit and wraps modulo 2^16. pcRegEn is asserted at most once per instruction outside a taken branch.
- irEn asserts only in FETCH. regFileEn and memWrite are never asserted in the same cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles from any state -> all outputs 0. Release -> first cycle is FETCH (irEn=1, regpcCont=01).
- ADD R3,R5 (16'h0355) -> 4-cycle sequence FETCH/DECODE/EXEC_R/WB. EXEC_R: aluControl=0000, mux4En=00, pcRegMuxEn=1, flagEn=1. WB: regFileEn=1, exMemResultEn=0.
- CMPI R2,#-1 (16'hB2FF) -> 3 cycles; EXEC_I signEn=1, mux4En=01, aluControl=0101, flagEn=1; regFileEn never asserted.
- LOAD R1,[R4] (16'h4104) -> LD_ADR then LD_WB with regpcCont=00 both cycles, exMemResultEn=1 and regFileEn=1 in LD_WB. STOR (16'h4144) -> memWrite=1 for exactly one cycle.
- BEQ disp=-3 (16'hC0FD): with flags Z=1 -> BRANCH pcRegEn=1, mux4En=01, aluControl=0000. With Z=0 -> pcRegEn=0 in BRANCH.
- Illegal opcode 16'hF000 -> FETCH, DECODE, FETCH. Reset asserted during LD_ADR -> next state FETCH, regFileEn never pulses.
